div: RTL



---
 rtl/div_pkg.sv | 30 +++
 rtl/div_step.sv | 29 ++
 rtl/div.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider and the EX stage that drives it.
// Optional feature macro used by div.sv: DIV_EARLY_OUT_EN.
package div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_STEPS  = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // ALU op codes shared with EX for the two divide instructions
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Magnitude of an operand: two's complement negate only for signed negatives
  function automatic logic [DIV_DATA_W-1:0] div_mag(input logic [DIV_DATA_W-1:0] v,
                                                    input logic is_signed);
    div_mag = (is_signed && v[DIV_DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration. Working register layout:
// [2W:W] partial remainder (W+1 bits), [W-1:0] remaining dividend bits / quotient bits.
module div_step
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [2*DATA_W:0] work,
  input  logic [DATA_W-1:0] divisor,
  output logic [2*DATA_W:0] work_next
);

  logic [2*DATA_W:0] shifted;
  logic [DATA_W:0]   trial;
  logic              unused_work_msb;

  // The remainder stays below the divisor, so the top bit is always clear before a shift
  assign unused_work_msb = work[2*DATA_W];

  // Shift in the next dividend bit, trial-subtract, keep the difference if it did not borrow
  always_comb begin
    shifted   = {work[2*DATA_W-1:0], 1'b0};
    trial     = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
    work_next = shifted;
    if (!trial[DATA_W])
      work_next = {trial, shifted[DATA_W-1:1], 1'b1};
  end

endmodule

// File: rtl/div.sv
// 32-bit radix-2 restoring divider serving EX as a stall-until-ready responder.
// result_o = {remainder, quotient}; remainder goes to HI, quotient to LO.
// Optional macro DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  div_state_e        state;
  logic [4:0]        cnt;
  logic [2*DATA_W:0] work;
  logic [2*DATA_W:0] work_next;
  logic [DATA_W-1:0] divisor;
  logic              neg_quot;
  logic              neg_rem;
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;

  div_step #(.DATA_W(DATA_W)) u_step (
    .work      (work),
    .divisor   (divisor),
    .work_next (work_next)
  );

  // Operand magnitudes and sign fix-up of the value the final step produces
  always_comb begin
    mag1     = div_mag(opdata1_i, signed_div_i);
    mag2     = div_mag(opdata2_i, signed_div_i);
    quot_fix = work_next[DATA_W-1:0];
    rem_fix  = work_next[2*DATA_W-1:DATA_W];
    if (neg_quot) quot_fix = ~quot_fix + 1'b1;
    if (neg_rem)  rem_fix  = ~rem_fix + 1'b1;
  end

  // Divider FSM; all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
      work     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (mag1 < mag2) begin
              // Quotient is zero and the remainder is the dividend as given
              state    <= DivEnd;
              result_o <= {opdata1_i, {DATA_W{1'b0}}};
              ready_o  <= DivResultReady;
            end
`endif
            else begin
              state    <= DivOn;
              cnt      <= '0;
              work     <= {{(DATA_W+1){1'b0}}, mag1};
              divisor  <= mag2;
              neg_quot <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_rem  <= signed_div_i && opdata1_i[DATA_W-1];
            end
          end
        end

        DivByZero: begin
          state    <= DivEnd;
          result_o <= '0;
          ready_o  <= DivResultReady;
        end

        DivOn: begin
          if (annul_i) begin
            // Flush wins even over the final step
            state    <= DivFree;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else begin
            work <= work_next;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'(DIV_STEPS - 1)) begin
              state    <= DivEnd;
              cnt      <= '0;
              result_o <= {rem_fix, quot_fix};
              ready_o  <= DivResultReady;
            end
          end
        end

        DivEnd: begin
          // Hold the result until EX drops its request
          if (start_i == DivStop) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end

        default: begin
          state <= DivFree;
        end
      endcase
    end
  end

endmodule
